// File: rtl/timer_ctrl_regs.sv
// Register front end for the timer: a bus handshake FSM, control and terminal-count
// registers, start/halt trigger pulse generation, and sticky maskable interrupt capture.
module timer_ctrl_regs #(
  parameter int TRIG_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_req_valid,
  output logic        bus_req_ready,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_rsp_valid,
  input  logic        bus_rsp_ready,
  output logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        ro_trig_start,
  output logic        ro_trig_halt,
  output logic        ro_mode,
  output logic [31:0] ro_termcount,
  input  logic        rf_status,
  input  logic [31:0] rf_currcount,
  input  logic        rf_int,
  output logic        irq
);

  localparam int              TCW       = $clog2(TRIG_W + 1);
  localparam logic [TCW-1:0]  TRIG_LOAD = TCW'(TRIG_W);
  localparam logic [CNT_W-1:0] EVCNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               mode_q, mode_d;
  logic               irq_en_q, irq_en_d;
  logic [31:0]        term_q, term_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   evcnt_q, evcnt_d;
  logic [TCW-1:0]     start_cnt_q, start_cnt_d;
  logic [TCW-1:0]     halt_cnt_q, halt_cnt_d;
  logic               start_q, start_d;
  logic               halt_q, halt_d;
  logic               irq_q, irq_d;

  logic               accept_s, addr_ok_s, wr_s, ctrl_wr_s, term_wr_s, w1c_s;
  logic               start_req_s, halt_req_s;
  logic [31:0]        rd_s;

  // Decode of the accepted request; writes only act on aligned addresses
  always_comb begin
    accept_s    = bus_req_valid & req_ready_q;
    addr_ok_s   = (bus_addr[1:0] == 2'b00);
    wr_s        = accept_s & bus_we & addr_ok_s;
    ctrl_wr_s   = wr_s & (bus_addr[3:2] == 2'd0);
    term_wr_s   = wr_s & (bus_addr[3:2] == 2'd1);
    w1c_s       = wr_s & (bus_addr[3:2] == 2'd2) & bus_wdata[1];
    halt_req_s  = ctrl_wr_s & bus_wdata[2];
    start_req_s = ctrl_wr_s & bus_wdata[1] & ~bus_wdata[2];
  end

  // Read mux, sampled into the response register at accept
  always_comb begin
    rd_s = 32'd0;
    case (bus_addr[3:2])
      2'd0: rd_s = {28'd0, irq_en_q, 1'b0, 1'b0, mode_q};
      2'd1: rd_s = term_q;
      2'd2: begin
        rd_s[0]          = rf_status;
        rd_s[1]          = pend_q;
        rd_s[8 +: CNT_W] = evcnt_q;
      end
      2'd3: rd_s = rf_currcount;
      default: rd_s = 32'd0;
    endcase
  end

  // Handshake FSM with registered ready/valid/data/error
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d     = RESP;
          req_ready_d = 1'b0;
          rsp_valid_d = 1'b1;
          err_d       = ~addr_ok_s;
          rdata_d     = (bus_we | ~addr_ok_s) ? 32'd0 : rd_s;
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (bus_rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rdata_d     = 32'd0;
          err_d       = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rdata_d     = 32'd0;
        err_d       = 1'b0;
      end
    endcase
  end

  // Trigger pulses: halt pre-empts an active start so the two never overlap
  always_comb begin
    start_cnt_d = (start_cnt_q == {TCW{1'b0}}) ? {TCW{1'b0}} : start_cnt_q - TCW'(1);
    halt_cnt_d  = (halt_cnt_q  == {TCW{1'b0}}) ? {TCW{1'b0}} : halt_cnt_q  - TCW'(1);
    if (halt_req_s && (halt_cnt_q == {TCW{1'b0}})) begin
      halt_cnt_d  = TRIG_LOAD;
      start_cnt_d = {TCW{1'b0}};
    end else if (start_req_s && (start_cnt_q == {TCW{1'b0}}) && (halt_cnt_q == {TCW{1'b0}})) begin
      start_cnt_d = TRIG_LOAD;
    end else begin
      start_cnt_d = start_cnt_d;
    end
    start_d = (start_cnt_d != {TCW{1'b0}});
    halt_d  = (halt_cnt_d  != {TCW{1'b0}});
  end

  // Control registers and interrupt capture; a same-cycle event beats the clear
  always_comb begin
    mode_d   = ctrl_wr_s ? bus_wdata[0] : mode_q;
    irq_en_d = ctrl_wr_s ? bus_wdata[3] : irq_en_q;
    term_d   = term_wr_s ? bus_wdata    : term_q;
    if (rf_int) begin
      pend_d  = 1'b1;
      evcnt_d = w1c_s ? CNT_W'(1) : ((evcnt_q == EVCNT_MAX) ? EVCNT_MAX : evcnt_q + CNT_W'(1));
    end else if (w1c_s) begin
      pend_d  = 1'b0;
      evcnt_d = {CNT_W{1'b0}};
    end else begin
      pend_d  = pend_q;
      evcnt_d = evcnt_q;
    end
    irq_d = pend_q & irq_en_q;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      mode_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      term_q      <= 32'd0;
      pend_q      <= 1'b0;
      evcnt_q     <= {CNT_W{1'b0}};
      start_cnt_q <= {TCW{1'b0}};
      halt_cnt_q  <= {TCW{1'b0}};
      start_q     <= 1'b0;
      halt_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mode_q      <= mode_d;
      irq_en_q    <= irq_en_d;
      term_q      <= term_d;
      pend_q      <= pend_d;
      evcnt_q     <= evcnt_d;
      start_cnt_q <= start_cnt_d;
      halt_cnt_q  <= halt_cnt_d;
      start_q     <= start_d;
      halt_q      <= halt_d;
      irq_q       <= irq_d;
    end
  end

  assign bus_req_ready = req_ready_q;
  assign bus_rsp_valid = rsp_valid_q;
  assign bus_rdata     = rdata_q;
  assign bus_err       = err_q;
  assign ro_trig_start = start_q;
  assign ro_trig_halt  = halt_q;
  assign ro_mode       = mode_q;
  assign ro_termcount  = term_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_timer_ctrl_regs.sv
// Directed and randomized bench for timer_ctrl_regs against a transaction-level
// register model; expectations are derived from the register map rules.
module tb_timer_ctrl_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_rsp_valid, bus_rsp_ready, bus_err;
  logic        ro_trig_start, ro_trig_halt, ro_mode;
  logic [31:0] ro_termcount;
  logic        rf_status, rf_int, irq;
  logic [31:0] rf_currcount;

  timer_ctrl_regs dut (
    .clk(clk), .reset(reset),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_ready(bus_rsp_ready),
    .bus_rdata(bus_rdata), .bus_err(bus_err),
    .ro_trig_start(ro_trig_start), .ro_trig_halt(ro_trig_halt),
    .ro_mode(ro_mode), .ro_termcount(ro_termcount),
    .rf_status(rf_status), .rf_currcount(rf_currcount), .rf_int(rf_int),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Register model
  logic        m_mode, m_irq_en, m_pend, m_irq, m_idle;
  logic [31:0] m_term;
  int          m_evcnt;
  bit          rand_en = 1'b0;
  logic        ts0, ts1, th0, th1;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    logic [7:0] ev;
    ev = 8'(m_evcnt);
    case (a[3:2])
      2'd0:    return {28'd0, m_irq_en, 1'b0, 1'b0, m_mode};
      2'd1:    return m_term;
      2'd2:    return {16'd0, ev, 6'd0, m_pend, rf_status};
      default: return rf_currcount;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 1'b0; m_irq_en = 1'b0; m_pend = 1'b0; m_irq = 1'b0;
    m_idle = 1'b1; m_term = 32'd0; m_evcnt = 0;
  endtask

  // One clock edge: predict its effect from the inputs presented, then check outputs
  task automatic tick();
    logic acc, wr, w1c, intr, old_pend, old_en;
    logic [1:0]  sel;
    logic [31:0] wd;
    acc = bus_req_valid && m_idle && !reset;
    wr  = acc && bus_we && (bus_addr[1:0] == 2'b00);
    sel = bus_addr[3:2];
    wd  = bus_wdata;
    w1c = wr && (sel == 2'd2) && wd[1];
    intr = rf_int;
    old_pend = m_pend;
    old_en = m_irq_en;
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      m_irq = old_pend & old_en;
      if (wr && sel == 2'd0) begin m_mode = wd[0]; m_irq_en = wd[3]; end
      if (wr && sel == 2'd1) m_term = wd;
      if (intr) begin
        m_pend = 1'b1;
        m_evcnt = w1c ? 1 : ((m_evcnt >= 255) ? 255 : m_evcnt + 1);
      end else if (w1c) begin
        m_pend = 1'b0;
        m_evcnt = 0;
      end
      if (acc) m_idle = 1'b0;
      else if (!m_idle && bus_rsp_ready) m_idle = 1'b1;
    end
    chk("irq", irq, m_irq);
    chk("ro_mode", ro_mode, m_mode);
    chk("ro_termcount", ro_termcount, m_term);
    if (rand_en) begin
      chk("no_trig", {ro_trig_start, ro_trig_halt}, 0);
      rf_int = ($urandom_range(0, 3) == 0);
      rf_status = $urandom_range(0, 1);
      rf_currcount = $urandom;
    end
  endtask

  // Full transaction with immediate response consumption
  task automatic xfer(input logic we, input logic [3:0] addr, input logic [31:0] wd);
    logic [31:0] er;
    logic ee;
    ee = (addr[1:0] != 2'b00);
    er = (we || ee) ? 32'd0 : exp_read(addr);
    bus_req_valid = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd; bus_rsp_ready = 1'b1;
    chk("req_ready_idle", bus_req_ready, 1);
    chk("rsp_valid_idle", bus_rsp_valid, 0);
    tick();
    bus_req_valid = 1'b0;
    ts0 = ro_trig_start; th0 = ro_trig_halt;
    chk("rsp_valid", bus_rsp_valid, 1);
    chk("req_ready_resp", bus_req_ready, 0);
    chk("rdata", bus_rdata, er);
    chk("err", bus_err, ee);
    last_rdata = bus_rdata;
    tick();
    ts1 = ro_trig_start; th1 = ro_trig_halt;
    chk("rsp_done", bus_rsp_valid, 0);
  endtask

  initial begin
    reset = 1'b1; bus_req_valid = 1'b0; bus_we = 1'b0; bus_addr = 4'd0; bus_wdata = 32'd0;
    bus_rsp_ready = 1'b1; rf_status = 1'b0; rf_int = 1'b0; rf_currcount = 32'h1234_5678;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_req_ready", bus_req_ready, 1);
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_trig", {ro_trig_start, ro_trig_halt}, 0);

    // Reset values via reads
    xfer(1'b0, 4'h0, 32'd0); chk("rd_ctrl_rst", last_rdata, 32'h0);
    xfer(1'b0, 4'h4, 32'd0); chk("rd_term_rst", last_rdata, 32'h0);
    rf_status = 1'b1;
    xfer(1'b0, 4'h8, 32'd0); chk("rd_status_rst", last_rdata, 32'h1);
    rf_status = 1'b0;
    xfer(1'b0, 4'hC, 32'd0); chk("rd_count", last_rdata, 32'h1234_5678);

    // TERM, MODE+START pulse of exactly two cycles
    xfer(1'b1, 4'h4, 32'h0000_0010);
    chk("termcount", ro_termcount, 32'h10);
    xfer(1'b1, 4'h0, 32'h3);
    chk("start_pulse", {ts0, ts1, th0, th1}, 4'b1100);
    chk("mode_set", ro_mode, 1);
    tick();
    chk("start_end", ro_trig_start, 0);
    xfer(1'b0, 4'h0, 32'd0); chk("rd_ctrl", last_rdata, 32'h1);

    // Back-to-back start: second write lands during the active pulse and is dropped
    xfer(1'b1, 4'h0, 32'h2);
    chk("start2_pulse", {ts0, ts1}, 2'b11);
    xfer(1'b1, 4'h0, 32'h2);
    chk("start_no_ext", {ts0, ts1, th0, th1}, 4'b0000);

    // Halt during an active start pulse
    xfer(1'b1, 4'h0, 32'h2);
    xfer(1'b1, 4'h0, 32'h4);
    chk("halt_preempt", {ts0, ts1, th0, th1}, 4'b0011);
    tick();
    chk("halt_end", ro_trig_halt, 0);

    // START+HALT together: halt only
    xfer(1'b1, 4'h0, 32'h6);
    chk("both_halt_only", {ts0, ts1, th0, th1}, 4'b0011);
    tick();
    chk("both_end", {ro_trig_start, ro_trig_halt}, 0);

    // Interrupt capture, status readback and clear
    xfer(1'b1, 4'h0, 32'h8);
    for (int i = 0; i < 3; i++) begin
      rf_int = 1'b1; tick(); rf_int = 1'b0; tick();
    end
    chk("irq_up", irq, 1);
    xfer(1'b0, 4'h8, 32'd0); chk("status_302", last_rdata, 32'h0000_0302);
    xfer(1'b1, 4'h8, 32'h2);
    xfer(1'b0, 4'h8, 32'd0); chk("status_clr", last_rdata, 32'h0);
    chk("irq_down", irq, 0);

    // Masking keeps PEND
    rf_int = 1'b1; tick(); rf_int = 1'b0;
    xfer(1'b1, 4'h0, 32'h0);
    tick();
    chk("irq_masked", irq, 0);
    xfer(1'b0, 4'h8, 32'd0); chk("pend_kept", last_rdata, 32'h0000_0102);

    // Event coincident with W1C: set wins, count restarts at 1
    rf_int = 1'b1;
    xfer(1'b1, 4'h8, 32'h2);
    rf_int = 1'b0;
    xfer(1'b0, 4'h8, 32'd0); chk("set_wins", last_rdata, 32'h0000_0202);

    // Saturation of the event counter
    rf_int = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    rf_int = 1'b0;
    xfer(1'b0, 4'h8, 32'd0); chk("evcnt_sat", last_rdata, 32'h0000_FF02);
    xfer(1'b1, 4'h8, 32'h2);

    // Misaligned access, then a held response
    xfer(1'b0, 4'h5, 32'd0);
    chk("misaligned_err", {bus_err, 1'b0}, 2'b00);
    xfer(1'b1, 4'h1, 32'hFFFF_FFFF);
    chk("misaligned_noeffect", ro_termcount, 32'h10);
    bus_req_valid = 1'b1; bus_we = 1'b0; bus_addr = 4'h5; bus_rsp_ready = 1'b0;
    tick();
    bus_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", bus_rsp_valid, 1);
      chk("hold_err", bus_err, 1);
      chk("hold_rdata", bus_rdata, 0);
      chk("hold_ready", bus_req_ready, 0);
      tick();
    end
    bus_rsp_ready = 1'b1;
    tick();
    chk("hold_release", {bus_rsp_valid, bus_req_ready}, 2'b01);

    // Randomized traffic against the model
    rand_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [3:0]  a;
      logic [31:0] wd;
      we = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      wd = $urandom;
      if (a[3:2] == 2'd0) wd = wd & 32'hFFFF_FFF9;
      xfer(we, a, wd);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_en = 1'b0;
    rf_int = 1'b0;
    tick();

    // Reset while in RESP with a start pulse active
    bus_req_valid = 1'b1; bus_we = 1'b1; bus_addr = 4'h0; bus_wdata = 32'h2; bus_rsp_ready = 1'b0;
    tick();
    bus_req_valid = 1'b0;
    chk("pre_rst_start", ro_trig_start, 1);
    chk("pre_rst_valid", bus_rsp_valid, 1);
    reset = 1'b1;
    tick();
    chk("rst_mid_valid", bus_rsp_valid, 0);
    chk("rst_mid_trig", {ro_trig_start, ro_trig_halt}, 0);
    chk("rst_mid_ready", bus_req_ready, 1);
    reset = 1'b0;
    bus_rsp_ready = 1'b1;
    tick();
    chk("post_rst_trig", ro_trig_start, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
